// File: rtl/trap_controller.sv
// Machine-mode trap controller: M-mode CSRs, exception/interrupt arbitration, mret,
// and a registered one-cycle PC redirect into fetch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal execution; requests and CSR writes are accepted
// REDIRECT | trapRedirect=1 for one cycle; every request is ignored
module trap_controller #(
    parameter int          N           = 64,
    parameter int          NUM_IRQ     = 16,
    parameter logic [N-1:0] MTVEC_RESET = N'('h1000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       PC_F,
    input  logic [15:0]        exceptSignal,
    input  logic [NUM_IRQ-1:0] interruptSignal,
    input  logic               mret,
    input  logic               csrWe,
    input  logic [11:0]        csrAddr,
    input  logic [N-1:0]       csrWData,
    output logic [N-1:0]       csrRData,
    output logic               trapRedirect,
    output logic [N-1:0]       PC_Trap,
    output logic [1:0]         privMode
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t               state, state_nxt;
    logic                 mstatus_mie, mstatus_mpie;
    logic [1:0]           mstatus_mpp;
    logic [NUM_IRQ-1:0]   mie_q, mip_q, pending;
    logic [N-1:0]         mtvec_q, mepc_q, mcause_q, pc_trap_q;
    logic [1:0]           priv_q;
    logic [5:0]           exc_code, irq_code, trap_code;
    logic                 take_exc, take_irq, take_mret, csr_wr;
    logic [N-1:0]         trap_base, trap_target;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        exc_code  = '0;
        irq_code  = '0;
        pending   = mip_q & mie_q;

        // lowest exception index wins, highest interrupt index wins
        for (int i = 15; i >= 0; i--)
            if (exceptSignal[i]) exc_code = 6'(i);
        for (int i = 0; i < NUM_IRQ; i++)
            if (pending[i]) irq_code = 6'(i);

        take_exc  = (state == RUN) && (|exceptSignal);
        take_irq  = (state == RUN) && !take_exc && mstatus_mie && (|pending);
        take_mret = (state == RUN) && !take_exc && !take_irq && mret;
        csr_wr    = (state == RUN) && csrWe && !take_exc && !take_irq && !take_mret;

        trap_code   = take_exc ? exc_code : irq_code;
        trap_base   = {mtvec_q[N-1:2], 2'b00};
        trap_target = (take_irq && mtvec_q[0]) ? trap_base + N'({trap_code, 2'b00})
                                               : trap_base;

        case (state)
            RUN:      if (take_exc || take_irq || take_mret) state_nxt = REDIRECT;
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mstatus_mpp  <= 2'b00;
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_q      <= MTVEC_RESET;
            mepc_q       <= '0;
            mcause_q     <= '0;
            pc_trap_q    <= '0;
            priv_q       <= 2'b11;
        end else begin
            mip_q <= interruptSignal;
            if (take_exc || take_irq) begin
                mepc_q       <= PC_F & ~N'(3);
                mcause_q     <= {take_irq, {(N-7){1'b0}}, trap_code};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                mstatus_mpp  <= priv_q;
                priv_q       <= 2'b11;
                pc_trap_q    <= trap_target;
            end else if (take_mret) begin
                pc_trap_q    <= mepc_q;
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
                priv_q       <= mstatus_mpp;
                mstatus_mpp  <= 2'b00;
            end else if (csr_wr) begin
                case (csrAddr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= csrWData[3];
                        mstatus_mpie <= csrWData[7];
                        // MPP only holds U or M; anything else collapses to M
                        mstatus_mpp  <= (csrWData[12:11] == 2'b00) ? 2'b00 : 2'b11;
                    end
                    ADDR_MIE:    mie_q    <= csrWData[NUM_IRQ-1:0];
                    ADDR_MTVEC:  mtvec_q  <= csrWData & ~N'(2);
                    ADDR_MEPC:   mepc_q   <= csrWData & ~N'(3);
                    ADDR_MCAUSE: mcause_q <= csrWData;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csrRData = '0;
        case (csrAddr)
            ADDR_MSTATUS: begin
                csrRData[3]     = mstatus_mie;
                csrRData[7]     = mstatus_mpie;
                csrRData[12:11] = mstatus_mpp;
            end
            ADDR_MIE:    csrRData[NUM_IRQ-1:0] = mie_q;
            ADDR_MTVEC:  csrRData = mtvec_q;
            ADDR_MEPC:   csrRData = mepc_q;
            ADDR_MCAUSE: csrRData = mcause_q;
            ADDR_MIP:    csrRData[NUM_IRQ-1:0] = mip_q;
            default:     csrRData = '0;
        endcase
    end

    assign trapRedirect = (state == REDIRECT);
    assign PC_Trap      = pc_trap_q;
    assign privMode     = priv_q;

endmodule
